// File: rtl/plab1_imul_zero_skip_mul_pkg.sv
// -----------------------------------------------------------------------------
// plab1_imul_zero_skip_mul_pkg
//   Shared constants and types for the zero-skipping iterative multiplier.
//   - state_t      : control FSM state encoding (IDLE / CALC / DONE)
//   - OPERAND_W    : operand and product width
//   - REQUEST_W    : request message width ({a, b})
//   - COUNT_W      : width of the trailing-zero count (0..8)
// -----------------------------------------------------------------------------
package plab1_imul_zero_skip_mul_pkg;

    localparam int OPERAND_W = 32;
    localparam int REQUEST_W = 64;
    localparam int COUNT_W   = 4;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/plab1_imul_zero_skip_mul_count_zeros.sv
// -----------------------------------------------------------------------------
// plab1_imul_CountZeros
//   8-bit trailing-zero counter.
//   Ports:
//     in_bits [7:0] : value to examine
//     count   [3:0] : number of trailing zeros, 0..7, or 8 when in_bits == 0
// -----------------------------------------------------------------------------
module plab1_imul_CountZeros
    import plab1_imul_zero_skip_mul_pkg::*;
(
    input  logic [7:0]         in_bits,
    output logic [COUNT_W-1:0] count
);

    // Scan from the top bit down so the lowest set bit is the last to win.
    always_comb begin
        count = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (in_bits[i]) begin
                count = COUNT_W'(i);
            end
        end
    end

endmodule

// File: rtl/plab1_imul_zero_skip_mul.sv
// -----------------------------------------------------------------------------
// plab1_imul_zero_skip_mul
//   Variable-latency iterative 32x32->32 multiplier. Each CALC cycle either
//   adds the multiplicand (multiplier LSB set) or skips a run of up to eight
//   zero multiplier bits in one step.
//   Ports:
//     clk      : clock, rising edge
//     reset    : asynchronous active-low reset
//     in_val   : request valid
//     in_rdy   : request ready (high only in IDLE and out of reset)
//     in_msg   : request {a[63:32], b[31:0]}
//     out_val  : response valid (high in DONE)
//     out_rdy  : response ready
//     out_msg  : low 32 bits of a*b
// -----------------------------------------------------------------------------
module plab1_imul_zero_skip_mul
    import plab1_imul_zero_skip_mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [REQUEST_W-1:0] in_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [OPERAND_W-1:0] out_msg
);

    state_t               state;
    logic [OPERAND_W-1:0] a_reg;
    logic [OPERAND_W-1:0] b_reg;
    logic [OPERAND_W-1:0] result_reg;
    logic [COUNT_W-1:0]   zero_count;

    plab1_imul_CountZeros u_count_zeros (
        .in_bits (b_reg[7:0]),
        .count   (zero_count)
    );

    // Control FSM and datapath share one sequential block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STATE_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (in_val) begin
                        a_reg      <= in_msg[63:32];
                        b_reg      <= in_msg[31:0];
                        result_reg <= '0;
                        state      <= STATE_CALC;
                    end
                end
                STATE_CALC: begin
                    if (b_reg == '0) begin
                        state <= STATE_DONE;
                    end else if (b_reg[0]) begin
                        result_reg <= result_reg + a_reg;
                        a_reg      <= a_reg << 1;
                        b_reg      <= b_reg >> 1;
                    end else begin
                        // zero_count is 1..8 here: the low bit is clear and
                        // b_reg is non-zero.
                        a_reg <= a_reg << zero_count;
                        b_reg <= b_reg >> zero_count;
                    end
                end
                STATE_DONE: begin
                    if (out_rdy) begin
                        state <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    // State resets to IDLE, so in_rdy is additionally gated by reset to stay
    // low while reset is held.
    assign in_rdy  = reset && (state == STATE_IDLE);
    assign out_val = (state == STATE_DONE);
    assign out_msg = result_reg;

endmodule

// File: tb/tb_plab1_imul_zero_skip_mul.sv
// -----------------------------------------------------------------------------
// tb_plab1_imul_zero_skip_mul
//   Self-checking bench: directed and random transactions compared against a
//   reference model of product and CALC-cycle count.
// -----------------------------------------------------------------------------
module tb_plab1_imul_zero_skip_mul;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [63:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;

    int checks = 0;
    int errors = 0;

    plab1_imul_zero_skip_mul dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // CALC cycles = 1 + popcount(b) + sum over zero runs below the top one
    // bit of ceil(run_length / 8).
    function automatic int model_latency(input logic [31:0] b);
        int ones;
        int skips;
        int run;
        ones  = 0;
        skips = 0;
        run   = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                ones++;
                skips += (run + 7) / 8;
                run = 0;
            end else begin
                run++;
            end
        end
        return 1 + ones + skips;
    endfunction

    // ---------------- transaction driver (no checking) ----------------
    // Sends one request and consumes the response. n_calc counts sampled
    // cycles after acceptance with out_val low. busy_rdy records whether
    // in_rdy was ever seen high between acceptance and consumption.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           output int n_calc, output logic [31:0] res,
                           output bit accepted, output bit busy_rdy,
                           output bit timeout);
        n_calc   = 0;
        res      = '0;
        busy_rdy = 1'b0;
        timeout  = 1'b0;
        @(negedge clk);
        accepted = in_rdy;
        in_val   = 1'b1;
        in_msg   = {a, b};
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
        in_msg = '0;
        while (!out_val && n_calc < 100) begin
            if (in_rdy) busy_rdy = 1'b1;
            n_calc++;
            @(negedge clk);
        end
        if (!out_val) begin
            timeout = 1'b1;
        end else begin
            if (in_rdy) busy_rdy = 1'b1;
            res     = out_msg;
            out_rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_rdy = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset   = 1'b0;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b0 || out_msg !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold val=%b rdy=%b msg=%h required 0 0 0", out_val, in_rdy, out_msg);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b val=%b required 1 0", in_rdy, out_val);
        end
        $display("reset: released, in_rdy=%b out_val=%b", in_rdy, out_val);
    endtask

    task automatic test_directed();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        int          tn [8];
        int          n;
        logic [31:0] res;
        bit          acc, busy, to;
        ta[0] = 32'd3;        tb[0] = 32'd5;        tn[0] = 4;
        ta[1] = 32'hDEADBEEF; tb[1] = 32'd0;        tn[1] = 1;
        ta[2] = 32'd0;        tb[2] = 32'hFFFFFFFF; tn[2] = 33;
        ta[3] = 32'd1;        tb[3] = 32'h80000000; tn[3] = 6;
        ta[4] = 32'hFFFFFFFF; tb[4] = 32'd7;        tn[4] = 4;
        ta[5] = 32'h00010000; tb[5] = 32'h00010000; tn[5] = 4;
        ta[6] = 32'd6;        tb[6] = 32'd7;        tn[6] = 4;
        ta[7] = 32'h12345678; tb[7] = 32'h00000100; tn[7] = 3;
        for (int i = 0; i < 8; i++) begin
            run_txn(ta[i], tb[i], n, res, acc, busy, to);
            checks++;
            if (to || !acc) begin
                errors++;
                $display("FAIL directed_handshake a=%h b=%h accepted=%b timeout=%b required 1 0", ta[i], tb[i], acc, to);
            end
            checks++;
            if (res !== model_product(ta[i], tb[i])) begin
                errors++;
                $display("FAIL directed_product a=%h b=%h got %h required %h", ta[i], tb[i], res, model_product(ta[i], tb[i]));
            end
            checks++;
            if (n != tn[i] || n != model_latency(tb[i])) begin
                errors++;
                $display("FAIL directed_latency a=%h b=%h got %0d required %0d", ta[i], tb[i], n, tn[i]);
            end
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL directed_busy_rdy a=%h b=%h in_rdy seen 1 while busy, required 0", ta[i], tb[i]);
            end
            $display("directed: a=%h b=%h -> %h in %0d calc cycles", ta[i], tb[i], res, n);
        end
    endtask

    task automatic test_random();
        int          n;
        logic [31:0] a, b, res;
        bit          acc, busy, to;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom & $urandom & $urandom;
                2: b = 32'd1 << $urandom_range(31, 0);
                default: b = ($urandom & 32'h8000_0101) | ($urandom_range(1, 0) << 20);
            endcase
            run_txn(a, b, n, res, acc, busy, to);
            checks++;
            if (to || !acc || busy) begin
                errors++;
                $display("FAIL random_handshake a=%h b=%h acc=%b busy=%b timeout=%b required 1 0 0", a, b, acc, busy, to);
            end
            checks++;
            if (res !== model_product(a, b)) begin
                errors++;
                $display("FAIL random_product a=%h b=%h got %h required %h", a, b, res, model_product(a, b));
            end
            checks++;
            if (n != model_latency(b)) begin
                errors++;
                $display("FAIL random_latency a=%h b=%h got %0d required %0d", a, b, n, model_latency(b));
            end
            $display("random: a=%h b=%h -> %h in %0d calc cycles", a, b, res, n);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [31:0] res;
        bit          acc, busy, to;
        @(negedge clk);
        in_val = 1'b1;
        in_msg = {32'd6, 32'd7};
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
        n = 0;
        while (!out_val && n < 100) begin
            n++;
            @(negedge clk);
        end
        // Present a competing request while the response is held back.
        in_val = 1'b1;
        in_msg = {32'd100, 32'd100};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_val !== 1'b1 || out_msg !== 32'd42 || in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d val=%b msg=%h rdy=%b required 1 0000002a 0", i, out_val, out_msg, in_rdy);
            end
            @(negedge clk);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_rdy = 1'b0;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_consume val=%b rdy=%b required 0 1", out_val, in_rdy);
        end
        // The ignored request must not have been captured.
        run_txn(32'd9, 32'd9, n, res, acc, busy, to);
        checks++;
        if (to || res !== 32'd81 || n != model_latency(32'd9)) begin
            errors++;
            $display("FAIL backpressure_next got %h in %0d required 00000051 in %0d", res, n, model_latency(32'd9));
        end
        $display("backpressure: held 42 for 5 cycles, next 9*9 -> %h", res);
    endtask

    task automatic test_back_to_back();
        int done_cycles;
        int calc;
        logic [31:0] a, b;
        out_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            a = $urandom;
            b = $urandom & 32'h00FF_0F0F;
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_idle t=%0d in_rdy=%b required 1", t, in_rdy);
            end
            in_val = 1'b1;
            in_msg = {a, b};
            @(posedge clk);
            @(negedge clk);
            in_val = 1'b0;
            calc = 0;
            while (!out_val && calc < 100) begin
                calc++;
                @(negedge clk);
            end
            done_cycles = 0;
            checks++;
            if (out_msg !== model_product(a, b)) begin
                errors++;
                $display("FAIL b2b_product t=%0d got %h required %h", t, out_msg, model_product(a, b));
            end
            while (out_val && done_cycles < 10) begin
                done_cycles++;
                @(negedge clk);
            end
            checks++;
            if (done_cycles != 1 || calc != model_latency(b)) begin
                errors++;
                $display("FAIL b2b_timing t=%0d done=%0d calc=%0d required 1 %0d", t, done_cycles, calc, model_latency(b));
            end
            $display("back_to_back: a=%h b=%h done_cycles=%0d calc=%0d", a, b, done_cycles, calc);
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int          n;
        logic [31:0] res;
        bit          acc, busy, to;
        @(negedge clk);
        in_val = 1'b1;
        in_msg = {32'd5, 32'hFFFFFFFF};
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b0 || out_msg !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid val=%b rdy=%b msg=%h required 0 0 0", out_val, in_rdy, out_msg);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle rdy=%b val=%b required 1 0", in_rdy, out_val);
        end
        run_txn(32'd2, 32'd3, n, res, acc, busy, to);
        checks++;
        if (to || res !== 32'd6 || n != 3) begin
            errors++;
            $display("FAIL reset_mid_after got %h in %0d required 00000006 in 3", res, n);
        end
        $display("reset_mid: abandoned 5*ffffffff, then 2*3 -> %h", res);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab1_imul_zero_skip_mul.md
Name: plab1_imul_zero_skip_mul

Overview:
- Variable-latency iterative 32x32->32 integer multiplier for the plab1 imul lab.
- Uses val/rdy request and response interfaces.
- Consumes the 8-bit trailing-zero count of the remaining multiplier bits. A run of up to 8 zero bits is skipped in a single cycle instead of one bit per cycle.
- Sits between the lab's source/sink test harness and the shared trailing-zero counter.

Parameters:
- none; all widths are fixed (operands 32, request 64, response 32).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_val  input  1  request valid
- in_rdy  output  1  request ready
- in_msg  input  64  request; a = in_msg[63:32], b = in_msg[31:0]
- out_val  output  1  response valid
- out_rdy  input  1  response ready
- out_msg  output  32  product, low 32 bits of a*b

Behaviour:
- Reset:
  - Asserting reset (0) immediately forces state IDLE and clears a_reg, b_reg and result_reg to 0.
  - While reset is asserted: out_val=0, in_rdy=0, out_msg=0.
  - Reset during CALC or DONE abandons the transaction; no response is ever produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_rdy=1 and out_val=0.
  - On in_val&in_rdy: a_reg<=a, b_reg<=b, result_reg<=0, next state CALC.
- CALC (in_rdy=0, out_val=0). Let c = trailing-zero count of b_reg[7:0], range 0..8. Exactly one of these applies each cycle:
  - b_reg==0: next state DONE; registers hold.
  - b_reg[0]==1: result_reg<=result_reg+a_reg (mod 2^32), a_reg<=a_reg<<1, b_reg<=b_reg>>1 (logical).
  - otherwise (c is 1..8): a_reg<=a_reg<<c, b_reg<=b_reg>>c. result_reg holds.
- DONE:
  - out_val=1 and out_msg=result_reg; in_rdy=0.
  - On out_rdy: next state IDLE.
  - out_msg is stable while out_val=1 and out_rdy=0.
- out_msg equals result_reg in every state; only its value during DONE is meaningful.
- Latency:
  - The request is accepted at edge E0.
  - State is CALC for N cycles, then DONE.
  - Minimum N=1 (b=0). Maximum N=33 (b=0xFFFFFFFF).
  - N = 1 + (number of one bits in b) + (number of zero-skip steps).
- Throughput: at most one transaction in flight. There is no accept in the cycle the response is consumed; IDLE lasts at least one cycle.
- Arithmetic:
  - All shifts are logical and shifted-out bits are discarded.
  - Signed operands multiply correctly mod 2^32.
  - Overflow is silently truncated; there is no overflow flag.
- Boundaries:
  - a=0 or b=0 gives product 0.
  - b=0x80000000 skips the zero run in 8-bit chunks.
  - in_val asserted outside IDLE is ignored and the message is not consumed.
  - out_rdy held high continuously still takes one DONE cycle, since out_val is registered by state.

Decomposition:
- Shared package/header holds:
  - state encoding constants STATE_IDLE=2'd0, STATE_CALC=2'd1, STATE_DONE=2'd2;
  - width constants: operand width 32, request width 64.
- Split into control FSM and datapath (a_reg, b_reg, result_reg, shifter, adder) in one file.
- One sub-module instance: plab1_imul_CountZeros, the team's 8-bit trailing-zero counter.
  - It is driven by b_reg[7:0] and its 4-bit count selects the shift amount.
  - A count of 8 means the low byte is zero.

Test Plan:
- Handshake and small operands: reset 0->1; send a=3, b=5 -> 4 CALC cycles, then out_val=1 with out_msg=15; in_rdy=0 from E0 until DONE is consumed.
- Zero operands: b=0, a=0xDEADBEEF -> out_msg=0 after exactly 1 CALC cycle; a=0, b=0xFFFFFFFF -> out_msg=0 after 33 CALC cycles.
- Zero skipping: a=1, b=0x80000000 -> out_msg=0x80000000 after 6 CALC cycles (skips 8, 8, 8, 7; then add; then detect zero).
- Signed and overflow: a=0xFFFFFFFF (-1), b=7 -> out_msg=0xFFFFFFF9; a=0x00010000, b=0x00010000 -> out_msg=0.
- Backpressure: hold out_rdy=0 for 5 cycles in DONE with a=6, b=7 -> out_val stays 1 and out_msg stays 42; in_val is ignored; the response is consumed on the first out_rdy=1 cycle.
- Reset mid-operation: accept a=5, b=0xFFFFFFFF; pulse reset low during cycle 10 of CALC -> out_val=0 and state IDLE immediately; after release, a=2, b=3 -> out_msg=6.
